// File: rtl/ifmap_window_addr_gen.sv
// -----------------------------------------------------------------------------
// ifmap_window_addr_gen
//
// Generates read addresses for an input-feature-map held in a circular buffer.
// Each row has a start/end descriptor. The block walks rows 0..last_row. In
// each row it slides a window head by `stride` and emits `filter_size`
// consecutive addresses per window on a valid/ready stream.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   cfg_we/cfg_row/     descriptor write port (only honoured while idle)
//   cfg_start/cfg_end
//   last_row, stride,   run parameters, latched on go
//   filter_size
//   go, abort           start pulse (idle only) / synchronous abort
//   raddr, raddr_valid, address stream; win_last marks the last address of
//   raddr_ready,        a window
//   win_last
//   row_done, done      one-cycle pulses at end of a row / end of the run
//   busy                high whenever the FSM is not idle
//   row_ptr_out         row currently being walked
//   state_dbg           current FSM state encoding
//
// Handshake: a beat transfers on a rising edge where raddr_valid && raddr_ready.
// While raddr_valid && !raddr_ready, raddr and win_last stay stable and
// raddr_valid stays high; only abort or reset can withdraw a pending beat.
// -----------------------------------------------------------------------------
module ifmap_window_addr_gen #(
  parameter int IF_MAP_HEIGHT  = 16,
  parameter int MAX_ROW        = 4,
  parameter int STRIDE_W       = 2,
  parameter int FILTER_W       = 4,
  localparam int ADD_WIDTH     = (IF_MAP_HEIGHT > 1) ? $clog2(IF_MAP_HEIGHT) : 1,
  localparam int ROW_PTR_WIDTH = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [ROW_PTR_WIDTH-1:0] cfg_row,
  input  logic [ADD_WIDTH-1:0]     cfg_start,
  input  logic [ADD_WIDTH-1:0]     cfg_end,
  input  logic [ROW_PTR_WIDTH-1:0] last_row,
  input  logic [STRIDE_W-1:0]      stride,
  input  logic [FILTER_W-1:0]      filter_size,
  input  logic                     go,
  input  logic                     abort,
  output logic [ADD_WIDTH-1:0]     raddr,
  output logic                     raddr_valid,
  input  logic                     raddr_ready,
  output logic                     win_last,
  output logic                     row_done,
  output logic                     done,
  output logic                     busy,
  output logic [ROW_PTR_WIDTH-1:0] row_ptr_out,
  output logic [2:0]               state_dbg
);

  // Wide enough that stride + filter_size - 1 never overflows.
  localparam int CW = ADD_WIDTH + FILTER_W + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_EMIT = 3'd2,
    S_ADV  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [ADD_WIDTH-1:0]     head_q, head_d;
  logic [ADD_WIDTH-1:0]     rem_q, rem_d;
  logic [FILTER_W-1:0]      off_q, off_d;
  logic [ROW_PTR_WIDTH-1:0] row_ptr_q, row_ptr_d;
  logic [STRIDE_W-1:0]      stride_q, stride_d;
  logic [FILTER_W-1:0]      fs_q, fs_d;
  logic [ROW_PTR_WIDTH-1:0] last_row_q, last_row_d;
  logic [ADD_WIDTH-1:0]     start_q [MAX_ROW];
  logic [ADD_WIDTH-1:0]     start_d [MAX_ROW];
  logic [ADD_WIDTH-1:0]     end_q   [MAX_ROW];
  logic [ADD_WIDTH-1:0]     end_d   [MAX_ROW];
  logic [ADD_WIDTH-1:0]     raddr_q, raddr_d;
  logic                     valid_q, valid_d;
  logic                     win_last_q, win_last_d;
  logic                     row_done_q, row_done_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

  logic [ADD_WIDTH-1:0]     load_start;
  logic [ADD_WIDTH-1:0]     load_rem;
  logic [CW-1:0]            fs_m1;
  logic                     fits_load;
  logic                     fits_next;
  logic                     fs_one;
  logic                     off_last;
  logic [FILTER_W-1:0]      off_nxt;
  logic                     row_finish;

  // rem is the wrapped distance from the window head to the row end, so a row
  // crossing the top of the buffer is handled without comparing raw addresses.
  assign load_start = start_q[row_ptr_q];
  assign load_rem   = end_q[row_ptr_q] - load_start;
  assign fs_m1      = CW'(fs_q) - CW'(1);
  assign fits_load  = CW'(load_rem) >= fs_m1;
  assign fits_next  = CW'(rem_q) >= (CW'(stride_q) + fs_m1);
  assign fs_one     = (fs_q == FILTER_W'(1));
  assign off_nxt    = off_q + FILTER_W'(1);
  assign off_last   = (off_q == fs_q - FILTER_W'(1));

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    rem_d      = rem_q;
    off_d      = off_q;
    row_ptr_d  = row_ptr_q;
    stride_d   = stride_q;
    fs_d       = fs_q;
    last_row_d = last_row_q;
    start_d    = start_q;
    end_d      = end_q;
    raddr_d    = raddr_q;
    valid_d    = valid_q;
    win_last_d = win_last_q;
    row_done_d = 1'b0;
    done_d     = 1'b0;
    row_finish = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          start_d[cfg_row] = cfg_start;
          end_d[cfg_row]   = cfg_end;
        end
        if (go) begin
          // Zero stride/filter_size are treated as 1; last_row is clamped.
          stride_d   = (stride == '0) ? STRIDE_W'(1) : stride;
          fs_d       = (filter_size == '0) ? FILTER_W'(1) : filter_size;
          last_row_d = (32'(last_row) > 32'(MAX_ROW - 1)) ?
                       ROW_PTR_WIDTH'(MAX_ROW - 1) : last_row;
          row_ptr_d  = '0;
          head_d     = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        head_d = load_start;
        rem_d  = load_rem;
        if (fits_load) begin
          off_d      = '0;
          raddr_d    = load_start;
          valid_d    = 1'b1;
          win_last_d = fs_one;
          state_d    = S_EMIT;
        end else begin
          row_finish = 1'b1;
        end
      end
      S_EMIT: begin
        if (valid_q && raddr_ready) begin
          if (off_last) begin
            valid_d    = 1'b0;
            win_last_d = 1'b0;
            state_d    = S_ADV;
          end else begin
            off_d      = off_nxt;
            raddr_d    = head_q + ADD_WIDTH'(off_nxt);
            win_last_d = (off_nxt == fs_q - FILTER_W'(1));
          end
        end
      end
      S_ADV: begin
        if (fits_next) begin
          head_d     = head_q + ADD_WIDTH'(stride_q);
          rem_d      = rem_q - ADD_WIDTH'(stride_q);
          off_d      = '0;
          raddr_d    = head_q + ADD_WIDTH'(stride_q);
          valid_d    = 1'b1;
          win_last_d = fs_one;
          state_d    = S_EMIT;
        end else begin
          row_finish = 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (row_finish) begin
      row_done_d = 1'b1;
      if (row_ptr_q == last_row_q) begin
        done_d  = 1'b1;
        state_d = S_FIN;
      end else begin
        row_ptr_d = row_ptr_q + ROW_PTR_WIDTH'(1);
        state_d   = S_LOAD;
      end
    end

    // Abort overrides everything, including a go in the same cycle.
    if (abort) begin
      state_d    = S_IDLE;
      valid_d    = 1'b0;
      win_last_d = 1'b0;
      row_done_d = 1'b0;
      done_d     = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      rem_q      <= '0;
      off_q      <= '0;
      row_ptr_q  <= '0;
      stride_q   <= '0;
      fs_q       <= '0;
      last_row_q <= '0;
      for (int i = 0; i < MAX_ROW; i++) begin
        start_q[i] <= '0;
        end_q[i]   <= '0;
      end
      raddr_q    <= '0;
      valid_q    <= 1'b0;
      win_last_q <= 1'b0;
      row_done_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      rem_q      <= rem_d;
      off_q      <= off_d;
      row_ptr_q  <= row_ptr_d;
      stride_q   <= stride_d;
      fs_q       <= fs_d;
      last_row_q <= last_row_d;
      start_q    <= start_d;
      end_q      <= end_d;
      raddr_q    <= raddr_d;
      valid_q    <= valid_d;
      win_last_q <= win_last_d;
      row_done_q <= row_done_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign raddr       = raddr_q;
  assign raddr_valid = valid_q;
  assign win_last    = win_last_q;
  assign row_done    = row_done_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign row_ptr_out = row_ptr_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ifmap_window_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_ifmap_window_addr_gen
//
// Directed and randomized runs of ifmap_window_addr_gen. A reference model
// expands each row descriptor into its full list of window addresses using
// plain arithmetic; a monitor on the falling edge checks accepted beats against
// that list, checks hold-while-stalled, and counts row_done/done pulses.
// -----------------------------------------------------------------------------
module tb_ifmap_window_addr_gen;

  localparam int H   = 16;
  localparam int NR  = 4;
  localparam int AW  = 4;
  localparam int RW  = 2;
  localparam int W   = AW + 1;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst;
  logic          cfg_we;
  logic [RW-1:0] cfg_row;
  logic [AW-1:0] cfg_start;
  logic [AW-1:0] cfg_end;
  logic [RW-1:0] last_row;
  logic [1:0]    stride;
  logic [3:0]    filter_size;
  logic          go;
  logic          abort;
  logic [AW-1:0] raddr;
  logic          raddr_valid;
  logic          raddr_ready;
  logic          win_last;
  logic          row_done;
  logic          done;
  logic          busy;
  logic [RW-1:0] row_ptr_out;
  logic [2:0]    state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  ifmap_window_addr_gen dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_row     (cfg_row),
    .cfg_start   (cfg_start),
    .cfg_end     (cfg_end),
    .last_row    (last_row),
    .stride      (stride),
    .filter_size (filter_size),
    .go          (go),
    .abort       (abort),
    .raddr       (raddr),
    .raddr_valid (raddr_valid),
    .raddr_ready (raddr_ready),
    .win_last    (win_last),
    .row_done    (row_done),
    .done        (done),
    .busy        (busy),
    .row_ptr_out (row_ptr_out),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int d_start [NR];
  int d_end   [NR];
  int total = 0;
  int bad   = 0;
  int exp_rows;
  int beat_cnt;
  int row_done_cnt;
  int done_cnt;
  bit done_seen;
  int first_rd_beats;
  int first_valid_edge;
  int go_edge;
  bit prev_stall = 1'b0;
  bit prev_done  = 1'b0;
  logic [W-1:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: every row of length len=(end-start mod H)+1 holds windows
  // at head offsets 0, s, 2s, ... while the whole window still fits.
  task automatic build_expected(input int lr, input int st, input int fs, output int rows);
    int s_eff;
    int f_eff;
    int lr_c;
    int len;
    logic [W-1:0] e;
    s_eff = (st == 0) ? 1 : st;
    f_eff = (fs == 0) ? 1 : fs;
    lr_c  = (lr > NR - 1) ? NR - 1 : lr;
    exp_q.delete();
    for (int r = 0; r <= lr_c; r++) begin
      len = ((d_end[r] - d_start[r] + H) % H) + 1;
      for (int h = 0; h + f_eff <= len; h += s_eff) begin
        for (int k = 0; k < f_eff; k++) begin
          e[W-1]   = (k == f_eff - 1);
          e[AW-1:0] = AW'((d_start[r] + h + k) % H);
          exp_q.push_back(e);
        end
      end
    end
    rows = lr_c + 1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(raddr_valid), 32'd1);
        chk("hold_data", 32'({win_last, raddr}), 32'(prev_data));
      end
      if (prev_done) chk("busy_after_done", 32'(busy), 32'd0);
      if (raddr_valid && first_valid_edge < 0) first_valid_edge = edge_cnt;
      if (raddr_valid && raddr_ready) begin
        chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("beat", 32'({win_last, raddr}), 32'(exp_q.pop_front()));
        beat_cnt++;
      end
      if (row_done) begin
        if (first_rd_beats < 0) first_rd_beats = beat_cnt;
        row_done_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_seen = 1'b1;
        chk("busy_in_fin", 32'(busy), 32'd1);
        chk("rows_at_done", 32'(row_done_cnt), 32'(exp_rows));
      end
      prev_stall = raddr_valid && !raddr_ready && !abort;
      prev_data  = {win_last, raddr};
      prev_done  = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    beat_cnt         = 0;
    row_done_cnt     = 0;
    done_cnt         = 0;
    done_seen        = 1'b0;
    first_rd_beats   = -1;
    first_valid_edge = -1;
  endtask

  task automatic write_desc(input int r, input int s, input int e);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_row = RW'(r); cfg_start = AW'(s); cfg_end = AW'(e);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    d_start[r] = s;
    d_end[r]   = e;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_raddr"},    32'(raddr),       32'd0);
    chk({tag, "_valid"},    32'(raddr_valid), 32'd0);
    chk({tag, "_win_last"}, 32'(win_last),    32'd0);
    chk({tag, "_row_done"}, 32'(row_done),    32'd0);
    chk({tag, "_done"},     32'(done),        32'd0);
    chk({tag, "_busy"},     32'(busy),        32'd0);
    chk({tag, "_row_ptr"},  32'(row_ptr_out), 32'd0);
  endtask

  task automatic start_go(input int lr, input int st, input int fs);
    int rows;
    build_expected(lr, st, fs, rows);
    exp_rows = rows;
    clear_stats();
    @(posedge clk); #1;
    last_row = RW'(lr); stride = 2'(st); filter_size = 4'(fs);
    go = 1'b1;
    go_edge = edge_cnt + 1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  // disturb: mid-run go / cfg write / parameter changes that must be ignored.
  task automatic run(input int lr, input int st, input int fs, input bit rnd, input bit disturb);
    int n;
    start_go(lr, st, fs);
    n = 0;
    while (!done_seen && n < 3000) begin
      raddr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
      if (disturb && n == 7) begin
        go = 1'b1; cfg_we = 1'b1; cfg_row = 2'd1; cfg_start = 4'd1; cfg_end = 4'd2;
        stride = 2'd3; filter_size = 4'd1; last_row = 2'd3;
      end else begin
        go = 1'b0; cfg_we = 1'b0;
      end
    end
    go = 1'b0; cfg_we = 1'b0; raddr_ready = 1'b1;
    chk("run_done_seen", 32'(done_seen), 32'd1);
    @(negedge clk);
    chk("run_leftover", 32'(exp_q.size()), 32'd0);
    chk("run_done_cnt", 32'(done_cnt), 32'd1);
    chk("run_row_done_cnt", 32'(row_done_cnt), 32'(exp_rows));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    rst = 1'b0; cfg_we = 1'b0; cfg_row = '0; cfg_start = '0; cfg_end = '0;
    last_row = '0; stride = '0; filter_size = '0; go = 1'b0; abort = 1'b0;
    raddr_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin d_start[i] = 0; d_end[i] = 0; end
    clear_stats();
    exp_rows = 0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    chk("reset_state", 32'(state_dbg), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    write_desc(0, 0, 7);
    write_desc(1, 8, 10);

    // Basic row: 0-3, 2-5, 4-7; first valid two cycles after go.
    run(0, 2, 4, 1'b0, 1'b0);
    chk("t1_latency", 32'(first_valid_edge - go_edge), 32'd1);

    // Same with random ready, plus ignored go/cfg/parameter changes mid-run.
    run(0, 2, 4, 1'b1, 1'b1);
    // Row 1 must still be 8..10 after the ignored write.
    run(1, 1, 2, 1'b1, 1'b0);

    // Wrap across the top of the buffer.
    write_desc(0, 14, 3);
    run(0, 1, 3, 1'b1, 1'b0);

    // Short row with no windows, then a normal row.
    write_desc(0, 4, 5);
    write_desc(1, 0, 2);
    run(1, 1, 3, 1'b0, 1'b0);
    chk("t4_rowdone_before_beats", 32'(first_rd_beats), 32'd0);

    // Zero stride / filter_size behave as 1.
    write_desc(0, 5, 7);
    run(0, 0, 0, 1'b1, 1'b0);

    // abort together with go in idle: stays idle.
    @(posedge clk); #1;
    go = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    go = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_go_busy", 32'(busy), 32'd0);
    chk("abort_go_state", 32'(state_dbg), 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_go_valid", 32'(raddr_valid), 32'd0);

    // Abort after the fifth beat: idle next cycle, no done pulse.
    write_desc(0, 0, 7);
    start_go(0, 2, 4);
    n = 0;
    while (beat_cnt < 5 && n < 100) begin @(negedge clk); n++; end
    chk("abort_wait", 32'(beat_cnt >= 5), 32'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(raddr_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_no_rowdone", 32'(row_done_cnt), 32'd0);
    exp_q.delete();

    // Reset mid-run: outputs clear without waiting for a clock edge.
    start_go(0, 2, 4);
    n = 0;
    while (beat_cnt < 3 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin d_start[i] = 0; d_end[i] = 0; end
    @(posedge clk); #1;
    rst = 1'b1;
    // Descriptors were cleared: row 0 is the single address 0.
    run(0, 1, 1, 1'b0, 1'b0);

    // Randomized configurations.
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < NR; r++) write_desc(r, $urandom_range(0, H - 1), $urandom_range(0, H - 1));
      run($urandom_range(0, NR - 1), $urandom_range(0, 3), $urandom_range(0, 15), 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
